// File: rtl/leaf_out_scheduler_pkg.sv
// Shared packet layout and types for the leaf output scheduler.
// Field offsets follow the 49-bit BFT packet {vld, leaf, port, addr, payload}.
package leaf_sched_pkg;

    localparam int PACKET_BITS   = 49;
    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;

    localparam int VLD_BIT  = 48;
    localparam int LEAF_MSB = 47;
    localparam int LEAF_LSB = 43;
    localparam int PORT_MSB = 42;
    localparam int PORT_LSB = 39;
    localparam int ADDR_MSB = 38;
    localparam int ADDR_LSB = 32;

    localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT_CFG       = 4'd0;
    localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT_FREESPACE = 4'd1;

    typedef struct packed {
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] port;
    } dest_t;

endpackage

// File: rtl/leaf_out_scheduler_if.sv
// Handshake bundle between user kernel / BFT side and the scheduler.
// master drives requests and control packets, slave returns grants.
interface leaf_out_scheduler_if
    import leaf_sched_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 2
);
    logic                                  resend;
    logic [PACKET_BITS-1:0]                din_bft;
    logic [PACKET_BITS-1:0]                dout_bft;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
    logic [NUM_OUT_PORTS-1:0]              vld_user;
    logic [NUM_OUT_PORTS-1:0]              ack_user;
    logic                                  cfg_done;

    modport master (
        output resend, din_bft, din_user, vld_user,
        input  dout_bft, ack_user, cfg_done
    );

    modport slave (
        input  resend, din_bft, din_user, vld_user,
        output dout_bft, ack_user, cfg_done
    );
endinterface

// File: rtl/leaf_out_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr,
// wrapping around to port 0.
module rr_arbiter #(
    parameter int  N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    always_comb begin
        automatic logic found = 1'b0;
        automatic int   idx   = 0;
        gnt = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/leaf_out_scheduler.sv
// Credit-based round-robin scheduler sharing one BFT output among user streams.
// Optional stall counter port enabled by LEAF_SCHED_STALL_CNT_EN.
module leaf_out_scheduler
    import leaf_sched_pkg::*;
#(
    parameter int NUM_OUT_PORTS         = 2,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    leaf_out_scheduler_if.slave bus
`ifdef LEAF_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);
    localparam int N  = NUM_OUT_PORTS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = NUM_BRAM_ADDR_BITS + 1;
    localparam int SW = CW + 8;
    localparam logic [CW-1:0] CRED_MAX = CW'(1 << NUM_BRAM_ADDR_BITS);

    logic [CW-1:0]          credit_q [N];
    logic [CW-1:0]          credit_d [N];
    dest_t                  dest_q   [N];
    dest_t                  dest_d   [N];
    logic [N-1:0]           cfg_vld_q, cfg_vld_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PACKET_BITS-1:0] dout_q, dout_d;
    logic                   cfg_done_q, cfg_done_d;

    logic                     ctl_vld, sel_ok, is_cfg, is_fs;
    logic [NUM_PORT_BITS-1:0] ctl_port;
    logic [2:0]               ctl_sel;
    dest_t                    ctl_dest;

    assign ctl_vld  = bus.din_bft[VLD_BIT];
    assign ctl_port = bus.din_bft[PORT_MSB:PORT_LSB];
    assign ctl_sel  = bus.din_bft[2:0];
    assign ctl_dest = bus.din_bft[16:8];
    assign sel_ok   = int'(ctl_sel) < N;
    assign is_cfg   = ctl_vld && sel_ok && ctl_port == CTRL_PORT_CFG;
    assign is_fs    = ctl_vld && sel_ok && ctl_port == CTRL_PORT_FREESPACE;

    logic [N-1:0] req, gnt;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i] = bus.vld_user[i] & cfg_vld_q[i]
                   & (credit_q[i] != '0) & ~bus.resend;
        end
    end

    rr_arbiter #(.N(N)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    logic                    any_gnt;
    logic [PW-1:0]           gidx;
    logic [PAYLOAD_BITS-1:0] gword;
    dest_t                   gdest;

    always_comb begin
        any_gnt = |gnt;
        gidx    = '0;
        gword   = '0;
        gdest   = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gidx  = PW'(i);
                gword = bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                gdest = dest_q[i];
            end
        end
    end

    always_comb begin
        automatic logic [SW-1:0] sum = '0;
        cfg_vld_d = cfg_vld_q;
        for (int i = 0; i < N; i++) begin
            dest_d[i] = dest_q[i];
            sum = SW'(credit_q[i]);
            if (is_fs && int'(ctl_sel) == i) sum = sum + SW'(FREESPACE_UPDATE_SIZE);
            if (gnt[i]) sum = sum - SW'(1);
            credit_d[i] = (sum > SW'(CRED_MAX)) ? CRED_MAX : sum[CW-1:0];
            if (is_cfg && int'(ctl_sel) == i) begin
                dest_d[i]    = ctl_dest;
                cfg_vld_d[i] = 1'b1;
            end
        end
        ptr_d  = ptr_q;
        dout_d = '0;
        if (any_gnt) begin
            ptr_d  = (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
            dout_d = {1'b1, gdest, NUM_ADDR_BITS'(gidx), gword};
        end
        cfg_done_d = &cfg_vld_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                credit_q[i] <= CRED_MAX;
                dest_q[i]   <= '0;
            end
            cfg_vld_q  <= '0;
            ptr_q      <= '0;
            dout_q     <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                credit_q[i] <= credit_d[i];
                dest_q[i]   <= dest_d[i];
            end
            cfg_vld_q  <= cfg_vld_d;
            ptr_q      <= ptr_d;
            dout_q     <= dout_d;
            cfg_done_q <= cfg_done_d;
        end
    end

`ifdef LEAF_SCHED_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        blocked;

    assign blocked = (|(bus.vld_user & cfg_vld_q)) & ~any_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (blocked && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign bus.ack_user = gnt;
    assign bus.dout_bft = dout_q;
    assign bus.cfg_done = cfg_done_q;

endmodule

// File: tb/tb_leaf_out_scheduler.sv
// Randomized and directed bench for leaf_out_scheduler against a credit/rr model.
// Define LEAF_SCHED_STALL_CNT_EN to also check the stall counter.
module tb_leaf_out_scheduler;
    import leaf_sched_pkg::*;

    localparam int NP = 2;
    localparam int CMAX = 128;
    localparam int FS = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    leaf_out_scheduler_if #(.NUM_OUT_PORTS(NP)) bus ();

`ifdef LEAF_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    leaf_out_scheduler #(.NUM_OUT_PORTS(NP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef LEAF_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference state
    int           m_credit [NP];
    bit [NP-1:0]  m_cfg;
    logic [8:0]   m_dest [NP];
    int           m_ptr;
    logic [48:0]  m_dout;
    longint       m_stall;
    logic [NP-1:0] seen_ack;

    function automatic logic [48:0] mk_cfg(input int p, input logic [4:0] lf,
                                           input logic [3:0] pt);
        return {1'b1, 5'd0, 4'd0, 7'd0, 15'd0, lf, pt, 5'd0, 3'(p)};
    endfunction

    function automatic logic [48:0] mk_fs(input int p);
        return {1'b1, 5'd0, 4'd1, 7'd0, 29'd0, 3'(p)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_credit[i] = CMAX;
            m_dest[i] = '0;
        end
        m_cfg = '0;
        m_ptr = 0;
        m_dout = '0;
        m_stall = 0;
    endtask

    task automatic idle_inputs();
        bus.din_bft = '0;
        bus.vld_user = '0;
        bus.din_user = '0;
        bus.resend = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_dout", 64'(bus.dout_bft), 64'd0);
        check("rst_ack", 64'(bus.ack_user), 64'd0);
        check("rst_cfg_done", 64'(bus.cfg_done), 64'd0);
`ifdef LEAF_SCHED_STALL_CNT_EN
        check("rst_stall", 64'(stall_cnt), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step(input logic [48:0] pkt, input logic [NP-1:0] vld,
                        input logic [NP*32-1:0] data, input logic rs);
        int g;
        int idx;
        int c;
        int pf;
        int p;
        logic [NP-1:0] exp_ack;
        @(negedge clk);
        bus.din_bft = pkt;
        bus.vld_user = vld;
        bus.din_user = data;
        bus.resend = rs;
        #1;
        g = -1;
        if (!rs) begin
            for (int k = 0; k < NP; k++) begin
                idx = (m_ptr + k) % NP;
                if (g < 0 && vld[idx] && m_cfg[idx] && m_credit[idx] > 0) g = idx;
            end
        end
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        seen_ack = bus.ack_user;
        check("ack", 64'(bus.ack_user), 64'(exp_ack));
        check("dout", 64'(bus.dout_bft), 64'(m_dout));
        check("cfg_done", 64'(bus.cfg_done), 64'(&m_cfg));
`ifdef LEAF_SCHED_STALL_CNT_EN
        check("stall", 64'(stall_cnt), 64'(m_stall));
`endif
        if ((|(vld & m_cfg)) && g < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_dout = (g >= 0) ? {1'b1, m_dest[g], 7'(g), data[g*32 +: 32]} : '0;
        pf = int'(pkt[42:39]);
        p = int'(pkt[2:0]);
        for (int i = 0; i < NP; i++) begin
            c = m_credit[i];
            if (pkt[48] && pf == 1 && p == i) c += FS;
            if (g == i) c -= 1;
            m_credit[i] = (c > CMAX) ? CMAX : c;
        end
        if (pkt[48] && pf == 0 && p < NP) begin
            m_cfg[p] = 1'b1;
            m_dest[p] = pkt[16:8];
        end
        if (g >= 0) m_ptr = (g + 1) % NP;
    endtask

    function automatic logic [NP*32-1:0] rnd_data();
        logic [NP*32-1:0] d;
        for (int i = 0; i < NP; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        int acks;
        logic [48:0] exp_w;
        logic [48:0] pkt;
        idle_inputs();
        model_reset();

        // T1: configure, single word on port 0
        do_reset();
        step(mk_cfg(0, 5'd3, 4'd2), 2'b00, '0, 1'b0);
        step(mk_cfg(1, 5'd5, 4'd4), 2'b00, '0, 1'b0);
        step('0, 2'b01, {32'd0, 32'hA5A5_0001}, 1'b0);
        check("t1_ack", 64'(seen_ack), 64'd1);
        step('0, 2'b00, '0, 1'b0);
        exp_w = {1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5_0001};
        check("t1_dout", 64'(bus.dout_bft), 64'(exp_w));

        // T2: alternation
        do_reset();
        step(mk_cfg(0, 5'd3, 4'd2), 2'b00, '0, 1'b0);
        step(mk_cfg(1, 5'd5, 4'd4), 2'b00, '0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step('0, 2'b11, rnd_data(), 1'b0);
            check("t2_alt", 64'(seen_ack), (k % 2 == 0) ? 64'd1 : 64'd2);
        end

        // T3: credit exhaustion then one freespace update
        do_reset();
        step(mk_cfg(0, 5'd1, 4'd1), 2'b00, '0, 1'b0);
        step(mk_cfg(1, 5'd2, 4'd2), 2'b00, '0, 1'b0);
        acks = 0;
        for (int k = 0; k < 132; k++) begin
            step('0, 2'b01, rnd_data(), 1'b0);
            if (seen_ack[0]) acks++;
        end
        check("t3_drain", 64'(acks), 64'd128);
        check("t3_dout_idle", 64'(bus.dout_bft[48]), 64'd0);
        step(mk_fs(0), 2'b01, rnd_data(), 1'b0);
        acks = 0;
        for (int k = 0; k < 70; k++) begin
            step('0, 2'b01, rnd_data(), 1'b0);
            if (seen_ack[0]) acks++;
        end
        check("t3_refill", 64'(acks), 64'd64);

        // T4: unconfigured port never acked
        do_reset();
        step(mk_cfg(0, 5'd7, 4'd3), 2'b10, rnd_data(), 1'b0);
        for (int k = 0; k < 4; k++) step('0, 2'b10, rnd_data(), 1'b0);
        check("t4_noack", 64'(seen_ack), 64'd0);
        check("t4_notdone", 64'(bus.cfg_done), 64'd0);
        step(mk_cfg(1, 5'd9, 4'd6), 2'b00, '0, 1'b0);
        step('0, 2'b00, '0, 1'b0);
        check("t4_done", 64'(bus.cfg_done), 64'd1);

        // T5: resend freeze mid-stream
        for (int k = 0; k < 4; k++) step('0, 2'b11, rnd_data(), 1'b0);
        for (int k = 0; k < 3; k++) begin
            step('0, 2'b11, rnd_data(), 1'b1);
            check("t5_frozen", 64'(seen_ack), 64'd0);
        end
        for (int k = 0; k < 4; k++) step('0, 2'b11, rnd_data(), 1'b0);

        // T6: freespace + grant at credit 100 saturates at 128
        do_reset();
        step(mk_cfg(0, 5'd4, 4'd1), 2'b00, '0, 1'b0);
        step(mk_cfg(1, 5'd6, 4'd2), 2'b00, '0, 1'b0);
        for (int k = 0; k < 28; k++) step('0, 2'b01, rnd_data(), 1'b0);
        step(mk_fs(0), 2'b01, rnd_data(), 1'b0);
        check("t6_grant", 64'(seen_ack), 64'd1);
        acks = 0;
        for (int k = 0; k < 132; k++) begin
            step('0, 2'b01, rnd_data(), 1'b0);
            if (seen_ack[0]) acks++;
        end
        check("t6_sat", 64'(acks), 64'd128);

        // random traffic, with one asynchronous reset in the middle
        for (int k = 0; k < 800; k++) begin
            if (k == 400) begin
                do_reset();
            end
            pkt = '0;
            case ($urandom % 4)
                0: pkt = mk_cfg($urandom % 4, 5'($urandom), 4'($urandom));
                1: pkt = mk_fs($urandom % 4);
                2: begin
                    pkt = mk_fs($urandom % 4);
                    pkt[42:39] = 4'(2 + $urandom % 14);
                end
                default: pkt = '0;
            endcase
            step(pkt, NP'($urandom), rnd_data(), ($urandom % 8) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
